store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Word-granular store buffer between EX/MEM glue and the d-cache: FIFO of stores
// with same-address coalescing, youngest-match load forwarding and a valid/ready drain port.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic                       i_mem_action,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_ready,
    output logic                       o_load_hit,
    output logic [DATA_WIDTH-1:0]      o_load_data,
    output logic                       o_load_miss,
    output logic                       o_drain_valid,
    output logic [ADDR_WIDTH-1:0]      o_drain_addr,
    output logic [DATA_WIDTH-1:0]      o_drain_data,
    input  logic                       i_drain_ready,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      ent_valid;
    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  is_load;
    logic                  is_store;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  co_hit;
    logic [PTR_W-1:0]      co_idx;
    logic                  push;
    logic                  coalesce;
    logic                  pop;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int offset);
        return base + PTR_W'(offset);
    endfunction

    // Walk from oldest to youngest so the last match seen is the youngest;
    // offset 0 is the head, which may forward but never absorbs a coalesce.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        co_hit   = 1'b0;
        co_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[slot(head, i)] && ent_addr[slot(head, i)] == i_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[slot(head, i)];
                if (i != 0) begin
                    co_hit = 1'b1;
                    co_idx = slot(head, i);
                end
            end
        end
    end

    assign o_full   = (count == CNT_W'(DEPTH));
    assign o_empty  = (count == '0);
    assign o_count  = count;

    assign is_load  = i_valid & ~i_mem_action;
    assign is_store = i_valid &  i_mem_action;
    assign coalesce = is_store & co_hit;
    assign push     = is_store & ~co_hit & ~o_full;
    assign pop      = ~o_empty & i_drain_ready;

    assign o_ready     = is_load | coalesce | push;
    assign o_load_hit  = is_load & fwd_hit;
    assign o_load_miss = is_load & ~fwd_hit;
    assign o_load_data = o_load_hit ? fwd_data : '0;

    // Drain fields read as zero while empty so stale popped entries never leak out.
    assign o_drain_valid = ~o_empty;
    assign o_drain_addr  = o_empty ? '0 : ent_addr[head];
    assign o_drain_data  = o_empty ? '0 : ent_data[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= i_addr;
                ent_data[tail]  <= i_data;
                tail            <= tail + PTR_W'(1);
            end
            if (coalesce) begin
                ent_data[co_idx] <= i_data;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_mem_action = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_drain_ready = 1'b0;
    logic          o_ready;
    logic          o_load_hit;
    logic [DW-1:0] o_load_data;
    logic          o_load_miss;
    logic          o_drain_valid;
    logic [AW-1:0] o_drain_addr;
    logic [DW-1:0] o_drain_data;
    logic          o_full;
    logic          o_empty;
    logic [2:0]    o_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t model_q[$];

    store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_mem_action  (i_mem_action),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_load_hit    (o_load_hit),
        .o_load_data   (o_load_data),
        .o_load_miss   (o_load_miss),
        .o_drain_valid (o_drain_valid),
        .o_drain_addr  (o_drain_addr),
        .o_drain_data  (o_drain_data),
        .i_drain_ready (i_drain_ready),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are held until the
    // next one; callers may check literal expectations right after this returns.
    task automatic applyStimulus(input logic v, input logic act, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic dr);
        @(posedge clk);
        #1;
        i_valid       = v;
        i_mem_action  = act;
        i_addr        = a;
        i_data        = d;
        i_drain_ready = dr;
        #2;
    endtask

    // Reference model: the buffer is an ordered list, oldest first.
    always @(negedge clk) begin
        logic          is_load;
        logic          is_store;
        logic          exp_hit;
        logic [DW-1:0] exp_ldata;
        logic          exp_ready;
        logic          do_pop;
        int            co;
        int            sz;
        entry_t        tmp;

        if (rst) model_q.delete();
        sz        = model_q.size();
        is_load   = i_valid & ~i_mem_action;
        is_store  = i_valid &  i_mem_action;
        exp_hit   = 1'b0;
        exp_ldata = '0;
        co        = -1;
        if (is_load) begin
            for (int k = 0; k < sz; k++) begin
                if (model_q[k].addr == i_addr) begin
                    exp_hit   = 1'b1;
                    exp_ldata = model_q[k].data;
                end
            end
        end
        if (is_store) begin
            for (int k = 1; k < sz; k++) begin
                if (model_q[k].addr == i_addr) co = k;
            end
        end
        exp_ready = is_load | (is_store & ((co >= 0) | (sz < DEPTH)));

        checkOutput("ready",       64'(o_ready),       64'(exp_ready));
        checkOutput("load_hit",    64'(o_load_hit),    64'(exp_hit));
        checkOutput("load_miss",   64'(o_load_miss),   64'(is_load & ~exp_hit));
        checkOutput("load_data",   64'(o_load_data),   64'(exp_ldata));
        checkOutput("count",       64'(o_count),       64'(sz));
        checkOutput("full",        64'(o_full),        64'(sz == DEPTH));
        checkOutput("empty",       64'(o_empty),       64'(sz == 0));
        checkOutput("drain_valid", 64'(o_drain_valid), 64'(sz != 0));
        checkOutput("drain_addr",  64'(o_drain_addr),  sz != 0 ? 64'(model_q[0].addr) : 64'd0);
        checkOutput("drain_data",  64'(o_drain_data),  sz != 0 ? 64'(model_q[0].data) : 64'd0);

        if (!rst) begin
            do_pop = (sz != 0) && i_drain_ready;
            if (is_store && co >= 0) begin
                tmp        = model_q[co];
                tmp.data   = i_data;
                model_q[co] = tmp;
            end else if (is_store && sz < DEPTH) begin
                tmp.addr = i_addr;
                tmp.data = i_data;
                model_q.push_back(tmp);
            end
            if (do_pop) void'(model_q.pop_front());
        end
    end

    initial begin
        #12;
        rst = 1'b0;

        // Load into an empty buffer must miss.
        applyStimulus(1'b1, 1'b0, 26'h10, 32'h0, 1'b0);
        checkOutput("lit_reset_miss",   64'(o_load_miss),   64'd1);
        checkOutput("lit_reset_hit",    64'(o_load_hit),    64'd0);
        checkOutput("lit_reset_empty",  64'(o_empty),       64'd1);
        checkOutput("lit_reset_dvalid", 64'(o_drain_valid), 64'd0);

        // Fill, reject when full, coalesce into a non-head entry while full.
        for (int a = 1; a <= 4; a++)
            applyStimulus(1'b1, 1'b1, 26'(a), 32'(32'h100 + a), 1'b0);
        applyStimulus(1'b1, 1'b1, 26'h5, 32'h555, 1'b0);
        checkOutput("lit_full_ready", 64'(o_ready), 64'd0);
        checkOutput("lit_full_count", 64'(o_count), 64'd4);
        checkOutput("lit_full_flag",  64'(o_full),  64'd1);
        applyStimulus(1'b1, 1'b1, 26'h3, 32'hBEEF, 1'b0);
        checkOutput("lit_coalesce_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, 26'h3, 32'h0, 1'b0);
        checkOutput("lit_fwd_hit",  64'(o_load_hit),  64'd1);
        checkOutput("lit_fwd_data", 64'(o_load_data), 64'hBEEF);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("lit_drained_empty", 64'(o_empty), 64'd1);

        // Head is never coalesced; duplicate entry forwards the younger data.
        applyStimulus(1'b1, 1'b1, 26'h7, 32'hA, 1'b0);
        applyStimulus(1'b1, 1'b1, 26'h7, 32'hB, 1'b0);
        checkOutput("lit_dup_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, 26'h7, 32'h0, 1'b0);
        checkOutput("lit_dup_count", 64'(o_count),     64'd2);
        checkOutput("lit_dup_data",  64'(o_load_data), 64'hB);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("lit_drain_first", 64'(o_drain_data), 64'hA);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("lit_drain_second", 64'(o_drain_data), 64'hB);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

        // Steady push+pop at count 2 wraps the pointers.
        applyStimulus(1'b1, 1'b1, 26'h20, 32'h20, 1'b0);
        applyStimulus(1'b1, 1'b1, 26'h21, 32'h21, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 26'(8'h30 + i), 32'(32'h300 + i), 1'b1);
            checkOutput("lit_steady_count", 64'(o_count), 64'd2);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);

        // Asynchronous reset mid-cycle with three queued stores.
        for (int a = 0; a < 3; a++)
            applyStimulus(1'b1, 1'b1, 26'(8'h40 + a), 32'(a + 1), 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("lit_rst_count",  64'(o_count),       64'd0);
        checkOutput("lit_rst_dvalid", 64'(o_drain_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 26'h41, 32'h0, 1'b0);
        checkOutput("lit_rst_miss", 64'(o_load_miss), 64'd1);

        // Randomized traffic over a small address window to provoke coalescing.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          26'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 2) == 0));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
